// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART receiver: register map, STATUS layout,
// RX state encoding and DIV clamping.
package apb_uart_pkg;

  localparam logic [4:0] ADDR_DATA   = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_CTRL   = 5'd2;
  localparam logic [4:0] ADDR_DIV    = 5'd3;

  localparam int unsigned ST_EMPTY = 4;
  localparam int unsigned ST_FULL  = 5;
  localparam int unsigned ST_FERR  = 6;
  localparam int unsigned ST_OVR   = 7;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/apb_uart_rx_slave_fifo.sv
// Synchronous RX byte FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb_uart_rx_slave.sv
// APB slave exposing an 8N1 UART receiver: synchronizer, bit-timing FSM,
// RX FIFO and DATA/STATUS/CTRL/DIV registers.
module apb_uart_rx_slave
  import apb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        access, wr_en, rd_pop, wr_status;
  logic        rx_meta, rx_s;
  logic        rx_en, irq_en, frame_err, overrun;
  logic [15:0] div;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick;
  logic        load_half, load_full, sample_bit, push_byte, frame_set, overrun_set;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        unused_pwdata;

  rx_state_e state, next_state;

  // APB decode
  assign access    = psel & penable;
  assign pslverr   = access & ((paddr > ADDR_DIV) | (pwrite & (paddr == ADDR_DATA)));
  assign wr_en     = access & pwrite & ~pslverr;
  assign rd_pop    = access & ~pwrite & (paddr == ADDR_DATA);
  assign wr_status = wr_en & (paddr == ADDR_STATUS);
  assign pready    = 1'b1;
  assign unused_pwdata = ^pwdata[31:16];

  always_comb begin
    prdata = '0;
    if (access && !pwrite && !pslverr) begin
      case (paddr)
        ADDR_DATA:   prdata = fifo_empty ? '0 : {24'b0, fifo_dout};
        ADDR_STATUS: prdata = {24'b0, overrun, frame_err, fifo_full, fifo_empty, 4'(fifo_count)};
        ADDR_CTRL:   prdata = {30'b0, irq_en, rx_en};
        ADDR_DIV:    prdata = {16'b0, div};
        default:     prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (cnt <= 16'd1);

  always_ff @(posedge pclk) begin
    if (Reset) state <= RX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!rx_en) begin
      next_state = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE:  if (!rx_s) next_state = RX_START;
        RX_START: if (tick) next_state = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (tick && bit_idx == 3'd7) next_state = RX_STOP;
        RX_STOP:  if (tick) next_state = RX_IDLE;
        default:  next_state = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    push_byte  = 1'b0;
    frame_set  = 1'b0;
    if (rx_en) begin
      case (state)
        RX_IDLE:  load_half = ~rx_s;
        RX_START: load_full = tick & ~rx_s;
        RX_DATA: begin
          sample_bit = tick;
          load_full  = tick;
        end
        RX_STOP: begin
          push_byte = tick & rx_s;
          frame_set = tick & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  // DIV is read only at reload, so a DIV write lands on the next bit boundary.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (load_half)      cnt <= div >> 1;
      else if (load_full) cnt <= div;
      else if (cnt != '0) cnt <= cnt - 16'd1;
      if (load_half) bit_idx <= '0;
      if (sample_bit) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (pclk),
    .reset (Reset),
    .push  (push_byte),
    .pop   (rd_pop),
    .din   (shreg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign overrun_set = push_byte & fifo_full & ~rd_pop;

  always_ff @(posedge pclk) begin
    if (Reset) begin
      rx_en     <= 1'b1;
      irq_en    <= 1'b0;
      div       <= 16'(CLKS_PER_BIT);
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en && paddr == ADDR_CTRL) begin
        rx_en  <= pwdata[0];
        irq_en <= pwdata[1];
      end
      if (wr_en && paddr == ADDR_DIV) div <= clamp_div(pwdata[15:0]);
      frame_err <= frame_set   | (frame_err & ~(wr_status & pwdata[ST_FERR]));
      overrun   <= overrun_set | (overrun   & ~(wr_status & pwdata[ST_OVR]));
    end
  end

  assign irq = irq_en & (~fifo_empty | frame_err | overrun);

endmodule

// File: tb/tb_apb_uart_rx_slave.sv
// Scoreboard bench for apb_uart_rx_slave: APB tasks queue expected responses,
// a negedge monitor checks every access phase against the queue.
module tb_apb_uart_rx_slave;

  logic        pclk = 1'b0;
  logic        Reset;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, rx, irq;

  int unsigned bit_clks = 16;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    logic        chk_irq;
    logic        irq_v;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 pclk = ~pclk;

  apb_uart_rx_slave #(
    .CLKS_PER_BIT (10416),
    .FIFO_DEPTH   (8)
  ) dut (
    .pclk    (pclk),
    .Reset   (Reset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .rx      (rx),
    .irq     (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (psel && penable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_access: paddr=%0d got nothing queued expected an entry", paddr);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "/pready"}, {31'b0, pready}, 32'd1);
        chk({e.name, "/pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
        if (e.chk_data) chk({e.name, "/prdata"}, prdata, e.data);
        if (e.chk_irq)  chk({e.name, "/irq"}, {31'b0, irq}, {31'b0, e.irq_v});
      end
    end
  end

  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_err,
                     input logic chk_irq, input logic exp_irq, input string nm);
    exp_t e;
    e.data = exp_d; e.err = exp_err; e.chk_data = ~wr;
    e.chk_irq = chk_irq; e.irq_v = exp_irq; e.name = nm;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ex, input string nm);
    apb(1'b0, a, 32'd0, ex, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic rd_irq(input logic [4:0] a, input logic [31:0] ex, input logic ex_irq, input string nm);
    apb(1'b0, a, 32'd0, ex, 1'b0, 1'b1, ex_irq, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string nm);
    apb(1'b1, a, d, 32'd0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge pclk); #1;
    rx = 1'b0;
    repeat (bit_clks) @(posedge pclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) @(posedge pclk);
      #1;
    end
    rx = stop;
    repeat (bit_clks) @(posedge pclk);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge pclk);
  endtask

  initial begin
    Reset = 1'b1; rx = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 Reset = 1'b0;

    // reset values and DIV clamp
    rd(5'd0, 32'h0,    "rst_data");
    rd(5'd1, 32'h10,   "rst_status");
    rd(5'd2, 32'h1,    "rst_ctrl");
    rd(5'd3, 32'd10416, "rst_div");
    wr(5'd3, 32'd2, "div_wr2");
    rd(5'd3, 32'd4,  "div_clamp");
    wr(5'd3, 32'd16, "div_wr16");
    rd(5'd3, 32'd16, "div_16");

    // single frame
    send_frame(8'h55, 1'b1);
    rd(5'd1, 32'h01, "f55_status");
    rd(5'd0, 32'h55, "f55_data");
    rd(5'd1, 32'h10, "f55_status_after");
    rd(5'd0, 32'h00, "empty_read");

    // overrun
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    rd(5'd1, 32'hA8, "ovr_status");
    for (int i = 0; i < 8; i++) rd(5'd0, 32'(i), $sformatf("ovr_data_%0d", i));
    rd(5'd1, 32'h90, "ovr_status_drained");
    wr(5'd1, 32'h80, "ovr_clear");
    rd(5'd1, 32'h10, "ovr_cleared");

    // framing error and irq
    send_frame(8'hA5, 1'b0);
    repeat (20) @(posedge pclk);
    rd_irq(5'd1, 32'h50, 1'b0, "ferr_status_noirq");
    wr(5'd2, 32'h3, "irq_enable");
    rd_irq(5'd1, 32'h50, 1'b1, "ferr_irq");
    rd_irq(5'd2, 32'h3,  1'b1, "ctrl_irq_en");
    wr(5'd1, 32'h40, "ferr_clear");
    rd_irq(5'd1, 32'h10, 1'b0, "ferr_cleared");
    wr(5'd2, 32'h1, "irq_disable");

    // 3-cycle glitch, then a normal frame
    @(posedge pclk); #1 rx = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rx = 1'b1;
    repeat (30) @(posedge pclk);
    rd(5'd1, 32'h10, "glitch_status");
    send_frame(8'h3C, 1'b1);
    rd(5'd1, 32'h01, "post_glitch_status");
    rd(5'd0, 32'h3C, "post_glitch_data");

    // erroring accesses have no side effects
    send_frame(8'h77, 1'b1);
    apb(1'b0, 5'd7, 32'd0,  32'h0, 1'b1, 1'b0, 1'b0, "err_rd7");
    apb(1'b1, 5'd0, 32'hFF, 32'h0, 1'b1, 1'b0, 1'b0, "err_wr_data");
    apb(1'b1, 5'd9, 32'h7,  32'h0, 1'b1, 1'b0, 1'b0, "err_wr9");
    rd(5'd1, 32'h01, "err_status");
    rd(5'd3, 32'd16, "err_div");
    rd(5'd2, 32'h1,  "err_ctrl");
    rd(5'd0, 32'h77, "err_data");

    // pop on the very edge of a push into a full FIFO
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
    fork
      send_frame(8'h18, 1'b1);
      begin
        repeat (153) @(posedge pclk);
        rd(5'd0, 32'h10, "coinc_pop");
      end
    join
    rd(5'd1, 32'h28, "coinc_status");
    for (int i = 0; i < 8; i++) rd(5'd0, 32'(8'h11 + i), $sformatf("coinc_data_%0d", i));
    rd(5'd1, 32'h10, "coinc_drained");

    // reset mid-frame
    send_frame(8'h42, 1'b1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(posedge pclk);
        #1 Reset = 1'b1;
        @(posedge pclk);
        #1 Reset = 1'b0;
      end
    join
    rd(5'd1, 32'h10, "midrst_status");
    rd(5'd3, 32'd10416, "midrst_div");
    rd(5'd2, 32'h1, "midrst_ctrl");
    rd(5'd0, 32'h0, "midrst_data");

    repeat (3) @(posedge pclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_uart_rx_slave.md
# apb_uart_rx_slave

APB responder that receives 8N1 UART frames on `rx`, buffers bytes in a small FIFO, and exposes data, status and control registers to the APB bus. It is the slave end of the APB transfers the bus master issues, and the receiving end of the serial line the benches drive. It sits on one `Psel` slot of the APB interconnect alongside the memory and UART-TX slaves.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10416, reset value of the DIV register (100 MHz pclk, 9600 baud).
- `FIFO_DEPTH`, 8, RX FIFO entries (power of two, ≥2).

Ports:
- `pclk`  in  1  single clock; everything is synchronous to the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `psel`  in  1  slave select for this slot.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  5  register word index.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; valid while `psel & penable & !pwrite`, 0 otherwise.
- `pready`  out  1  always 1 (zero wait states).
- `pslverr`  out  1  error response, valid in the access phase.
- `rx`  in  1  asynchronous serial input, idle high.
- `irq`  out  1  level interrupt.

## Operation
- Registers (paddr):
  - 0 DATA (RO): `{24'b0, fifo_head}`. A read access pops the FIFO. A read while the FIFO is empty returns 0 and does not pop.
  - 1 STATUS: `[3:0]` count (RO), `[4]` empty (RO), `[5]` full (RO), `[6]` frame_err (W1C), `[7]` overrun (W1C).
  - 2 CTRL (RW): `[0]` rx_en (reset 1), `[1]` irq_en (reset 0).
  - 3 DIV (RW, 16 bits): clocks per bit. Writes of a value below 4 are clamped to 4.
- `pslverr` = 1 when paddr > 3, or on a write to DATA. An erroring access has no side effects.
- Access commits only when `psel & penable` (the access phase). A setup phase alone causes no pop and no write.
- `rx` passes through a 2-flop synchronizer. The FSM sees `rx_s`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when `rx_s` = 0 and rx_en = 1. Load the counter with DIV/2.
  - START: at count expiry, if `rx_s` = 0 go to DATA, reload DIV, bit index 0. Otherwise (glitch) return to IDLE.
  - DATA: sample `rx_s` at each DIV expiry, shifting LSB first. After the 8th sample go to STOP.
  - STOP: at DIV expiry, if `rx_s` = 1 push the byte. If `rx_s` = 0, set frame_err and discard the byte. Then go to IDLE.
- Push with the FIFO full: drop the byte and set overrun. The existing contents are unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged. This applies even when the FIFO is full, since the pop frees the slot.
- A W1C write and a same-cycle set of the same flag: the set wins.
- Clearing rx_en mid-frame aborts the frame, with the FSM going to IDLE without a push. A DIV write takes effect at the next counter reload.
- `irq` = irq_en & (!empty | frame_err | overrun).
- Reset, including in the middle of a frame: FSM to IDLE, FIFO empty with pointers 0, flags 0, CTRL = 1, DIV = CLKS_PER_BIT, `prdata` = 0, `pslverr` = 0, `irq` = 0, synchronizer flops = 1.

## Timing
- `prdata` and `pslverr` are combinational in the access phase. The pop, write and W1C commit on the pclk edge that ends the access phase.
- Falling edge on `rx` to START: 2 cycles (synchronizer) + 1.
- Sample points: start at DIV/2, data bit n at DIV/2 + (n+1)·DIV, stop at DIV/2 + 9·DIV clocks after START entry.
- The byte is visible in DATA/STATUS on the cycle after the stop sample. `irq` asserts in the same cycle.
- Back-to-back frames: IDLE is entered right after the stop sample, so a start edge arriving during the second half of the stop bit is accepted.

## Structure
- Package `apb_uart_pkg`:
  - register index constants: ADDR_DATA = 0, ADDR_STATUS = 1, ADDR_CTRL = 2, ADDR_DIV = 3
  - STATUS bit positions
  - RX FSM state encoding
  - MIN_DIV = 4
- Sub-module `rx_fifo`: synchronous FIFO with push/pop/full/empty/count and an extra-bit pointer wrap. The top level holds the APB decode, the synchronizer, the FSM and the bit counter.

## Test plan
- Reset, then read all registers → DATA = 0, STATUS = 0x10, CTRL = 0x1, DIV = 10416, `pslverr` = 0.
- Write DIV = 16, then drive frame 0x55 (start, bits 1,0,1,0,1,0,1,0, stop) at 16 clk/bit → STATUS count 1; DATA read = 0x55; STATUS returns to 0x10.
- With DIV = 16, drive 9 frames 0x00..0x08 without reading → full = 1, overrun = 1; 8 reads return 0x00..0x07; writing 0x80 to STATUS clears overrun.
- Drive frame 0xA5 with the stop bit held low → frame_err = 1, count 0; with irq_en = 1, `irq` = 1 until 0x40 is written to STATUS.
- Drive a 3-cycle low glitch on `rx` with DIV = 16 → no push, FSM back in IDLE; also assert `Reset` mid-frame → no push, STATUS = 0x10.
- Read paddr = 7 and write paddr = 0 → `pslverr` = 1, no FIFO pop, no register change; a pop coinciding with a stop-bit push leaves the count unchanged.
